// File: rtl/contador_assincrono.sv
// Ripple (asynchronous) counter built from a chain of toggle flip-flops, up or down.
// Define CONTADOR_SYNC_OUT_EN to re-time count through a clk-sampled output register.
module contador_assincrono #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DOWN  = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] stage;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_stage
        logic stage_q;

        if (i == 0) begin : gen_first
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stage_q <= 1'b0;
                end else begin
                    stage_q <= ~stage_q;
                end
            end
        end else if (DOWN == 0) begin : gen_up
            // A 1->0 carry out of the previous stage advances this one.
            always_ff @(negedge stage[i-1] or posedge reset) begin
                if (reset) begin
                    stage_q <= 1'b0;
                end else begin
                    stage_q <= ~stage_q;
                end
            end
        end else begin : gen_down
            // A 0->1 borrow out of the previous stage advances this one.
            always_ff @(posedge stage[i-1] or posedge reset) begin
                if (reset) begin
                    stage_q <= 1'b0;
                end else begin
                    stage_q <= ~stage_q;
                end
            end
        end

        assign stage[i] = stage_q;
    end

`ifdef CONTADOR_SYNC_OUT_EN
    logic [WIDTH-1:0] count_q;

    // Samples the settled value from the previous period; stage 0 updates in the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= stage;
        end
    end

    assign count = count_q;
`else
    assign count = stage;
`endif

    // Decoded from count, not from the stages, so tc tracks whatever latency count has.
    assign tc = (DOWN == 0) ? (count == '1) : (count == '0);

endmodule

// File: tb/tb_contador_assincrono.sv
// Directed bench for contador_assincrono: up instance plus a DOWN=1 instance on one clock.
// Expected values follow the registered-output latency when CONTADOR_SYNC_OUT_EN is defined.
module tb_contador_assincrono;

`ifdef CONTADOR_SYNC_OUT_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif

    logic       clk;
    logic       reset;
    logic       reset_dn;
    logic [3:0] count;
    logic       tc;
    logic [3:0] count_dn;
    logic       tc_dn;

    int n_checks = 0;
    int n_fails  = 0;

    contador_assincrono #(
        .WIDTH(4),
        .DOWN (0)
    ) u_dut_up (
        .clk  (clk),
        .reset(reset),
        .count(count),
        .tc   (tc)
    );

    contador_assincrono #(
        .WIDTH(4),
        .DOWN (1)
    ) u_dut_dn (
        .clk  (clk),
        .reset(reset_dn),
        .count(count_dn),
        .tc   (tc_dn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Visible up-count after n rising edges since reset release.
    function automatic int up_val(input int n);
        return (n - SYNC) % 16;
    endfunction

    function automatic int dn_val(input int n);
        return (16 - (n - SYNC)) % 16;
    endfunction

    initial begin
        int v;
        reset    = 1'b0;
        reset_dn = 1'b1;

        // Reset pulse 40..80 ns.
        #40 reset = 1'b1;
        #10;
        check_val("rst_count_50", count, 0);
        check_val("rst_tc_50", tc, 0);
        check_val("dn_rst_count", count_dn, 0);
        check_val("dn_rst_tc", tc_dn, 1);
        #25;
        check_val("rst_count_75", count, 0);
        #5 reset = 1'b0;

        // Edges at 85, 95, 105, 115 ns.
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            #3;
            check_val("release_count", count, up_val(n));
        end

        // t=118: reset at 120 clears immediately.
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_120", count, 0);
        check_val("async_rst_tc", tc, 0);

        // Release at 160, then 17 edges through the wrap.
        #39 reset = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            @(posedge clk);
            #3;
            v = up_val(n);
            check_val("wrap_count", count, v);
            check_val("wrap_tc", tc, (v == 15) ? 1 : 0);
        end

        // Mid-cycle reset with count at 9.
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        for (int n = 1; n <= 9 + SYNC; n++) begin
            @(posedge clk);
            #3;
        end
        check_val("pre_mid_rst", count, 9);
        #1 reset = 1'b1;
        #1;
        check_val("mid_rst_count", count, 0);
        check_val("mid_rst_tc", tc, 0);
        repeat (3) begin
            @(posedge clk);
            #3;
            check_val("rst_hold_count", count, 0);
        end
        #1 reset = 1'b0;
        @(posedge clk);
        #3;
        check_val("after_mid_rst", count, up_val(1));

        // Down counter: release and two edges, checking mid-period stability.
        check_val("dn_pre_tc", tc_dn, 1);
        #1 reset_dn = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            @(posedge clk);
            #3;
            v = dn_val(n);
            check_val("dn_count", count_dn, v);
            check_val("dn_tc", tc_dn, (v == 0) ? 1 : 0);
            #4;
            check_val("dn_stable", count_dn, v);
        end

        // Three edges from reset, stable between edges.
        reset = 1'b1;
        #1;
        check_val("seq3_rst", count, 0);
        #1 reset = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk);
            #3;
            check_val("seq3_count", count, up_val(n));
            #4;
            check_val("seq3_stable", count, up_val(n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/contador_assincrono.md
CONTADOR_ASSINCRONO -- requirements
Module: contador_assincrono

Interface
REQ-001 Parameter WIDTH, default 4: number of counter stages and width of count.
REQ-002 Parameter DOWN, default 0: 0 = up counter, 1 = down counter.
REQ-003 Port clk  input  1  single clock; stage 0 advances on each rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset; clears every stage and output register.
REQ-005 Port count  output  WIDTH  current counter value.
REQ-006 Port tc  output  1  terminal count: high while count equals all-ones (DOWN=0) or all-zeros (DOWN=1).

Function
REQ-007 The counter SHALL be a ripple (asynchronous) chain of WIDTH toggle flip-flops; only stage 0 is clocked by clk.
REQ-008 Stage 0 SHALL toggle on every rising clk edge while reset is low.
REQ-009 With DOWN=0, stage i (i>0) SHALL toggle on the falling edge of stage i-1; with DOWN=1, on the rising edge of stage i-1.
REQ-010 With DOWN=0, count SHALL increment by 1 per clk rising edge, modulo 2^WIDTH; 15 -> 0 wraps with no stall (WIDTH=4).
REQ-011 With DOWN=1, count SHALL decrement by 1 per clk rising edge, modulo 2^WIDTH; 0 -> 15 wraps (WIDTH=4).
REQ-012 Ripple settling SHALL complete within one clk period; intermediate ripple values between edges are permitted on the raw output.
REQ-013 tc SHALL be decoded combinationally from the count output (not from internal stages), so it carries the same latency as count.
REQ-014 The first increment after reset deassertion SHALL occur on the first rising clk edge with reset low.
REQ-015 Reset asserted while clk toggles SHALL hold count at 0; no counting occurs while reset is high.
REQ-016 Before the first reset assertion the counter value is undefined (X in simulation); no power-on value is required.

Reset
REQ-017 Assertion of reset SHALL clear all stages and count to 0 immediately, independent of clk.
REQ-018 During reset, tc SHALL be 0 for DOWN=0 and 1 for DOWN=1.
REQ-019 Reset SHALL be applied asynchronously to every flip-flop, including the output register of REQ-021.

Configuration
REQ-020 Macro CONTADOR_SYNC_OUT_EN selects output registration.
REQ-021 With CONTADOR_SYNC_OUT_EN defined, count SHALL be the stage values sampled by a WIDTH-bit register on the rising clk edge: glitch-free, one clk of latency (count shows value N-1 after edge N).
REQ-022 Without CONTADOR_SYNC_OUT_EN, count SHALL be driven directly by the ripple stages: zero register latency, ripple glitches visible.

Verification (WIDTH=4, DOWN=0, clk period 10 ns, macro undefined unless stated)
REQ-023 Bench SHALL drive reset 0 from t=0, then toggle it every 40 ns. Required: count = 0 for 40-80 ns. After release at 80 ns, rising edges at 85, 95, 105 and 115 ns give count = 1, 2, 3, 4. Reset at 120 ns gives count = 0 at once.
REQ-024 Bench SHALL run 17 rising edges after reset release. Required: count runs 1..15, then 0, then 1. tc = 1 only while count = 15.
REQ-025 Bench SHALL assert reset mid-cycle at count = 9, away from any clk edge. Required: count = 0 within the same cycle; count stays 0 until reset falls.
REQ-026 With DOWN=1, bench SHALL release reset and apply 2 rising edges. Required: count = 15, then 14. tc = 1 during reset and 0 after the first edge.
REQ-027 With CONTADOR_SYNC_OUT_EN defined, bench SHALL release reset and apply 3 rising edges. Required: count = 0, 1, 2, always one edge behind the raw sequence. No glitches between edges.
